keypad_scanner: RTL and testbench



---
 rtl/calc_pkg.sv | 40 ++++
 rtl/keypad_scanner_tick_gen.sv | 26 ++
 rtl/keypad_scanner.sv | 117 +++++++++++
 tb/tb_keypad_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad map, scan states and row-decode helpers.
package calc_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } scan_state_t;

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_hit_t;

    // Indexed [row][col]
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic row_hit_t onehot_low_index(input logic [3:0] v);
        row_hit_t r;
        r = '0;
        case (v)
            4'b1110: r = '{single: 1'b1, idx: 2'd0};
            4'b1101: r = '{single: 1'b1, idx: 2'd1};
            4'b1011: r = '{single: 1'b1, idx: 2'd2};
            4'b0111: r = '{single: 1'b1, idx: 2'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks.
module tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(SCAN_DIV - 2);

    logic [CW-1:0] count;

    // tick is registered one count early so it is high exactly while count == LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= (count == LAST) ? '0 : count + CW'(1);
            tick  <= (count == PRE_LAST);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, 2-flop row sync, press/release debounce.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic        tick;
    logic [3:0]  row_m;
    logic [3:0]  row_s;
    row_hit_t    hit;
    scan_state_t state;
    logic [1:0]  col_idx;
    logic [1:0]  col_nxt;
    logic [1:0]  cand_row;
    logic [1:0]  cand_col;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] rel_cnt;

    tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    assign hit     = onehot_low_index(row_s);
    assign col_nxt = col_idx + 2'd1;

    // Scan/debounce FSM; column index only moves when leaving a column's decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= '0;
            col       <= 4'b1110;
            cand_row  <= '0;
            cand_col  <= '0;
            db_cnt    <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (hit.single) begin
                            cand_row <= hit.idx;
                            cand_col <= col_idx;
                            db_cnt   <= '0;
                            state    <= DEBOUNCE;
                        end else begin
                            col_idx <= col_nxt;
                            col     <= col_drive(col_nxt);
                        end
                    end
                    DEBOUNCE: begin
                        if (hit.single && hit.idx == cand_row) begin
                            if (db_cnt == D_LAST) begin
                                key_code  <= KEYMAP[cand_row][cand_col];
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                db_cnt    <= '0;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                db_cnt <= db_cnt + DW'(1);
                            end
                        end else begin
                            col_idx <= col_nxt;
                            col     <= col_drive(col_nxt);
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (row_s == 4'b1111) begin
                            if (rel_cnt == D_LAST) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                col_idx  <= col_nxt;
                                col      <= col_drive(col_nxt);
                                state    <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + DW'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix keypad model.
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int          vectors = 0;
    int          miscompares = 0;
    int          pulse_cnt = 0;
    logic [3:0]  last_code = '0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Key (r,c) shorts row r to column c; rows are pulled up
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt = pulse_cnt + 1;
            last_code = key_code;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int base, input int bound, input string tag);
        int n = 0;
        while (pulse_cnt == base && n < bound) begin
            step(1);
            n++;
        end
        check({tag, " pulse_timeout"}, 32'(pulse_cnt != base), 32'd1);
    endtask

    task automatic wait_held_low(input int bound, input string tag);
        int n = 0;
        while (key_held && n < bound) begin
            step(1);
            n++;
        end
        check({tag, " release_timeout"}, 32'(key_held), 32'd0);
    endtask

    task automatic wait_col(input logic [3:0] target, input logic want_eq, input int bound);
        int n = 0;
        while (((col == target) != want_eq) && n < bound) begin
            step(1);
            n++;
        end
        check("col_wait_timeout", 32'((col == target) == want_eq), 32'd1);
    endtask

    initial begin
        int         base;
        int         changes;
        logic       moved;
        logic [3:0] prev;
        logic [3:0] exp_col;

        // Reset asserted asynchronously mid-slot, then the column walk
        step(3);
        rst = 1'b0;
        step(6);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_col", 32'(col), 32'h0000000e);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        step(2);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_col = ~(4'b0001 << 2'((k / 4) % 4));
            check("walk_col", 32'(col), 32'(exp_col));
        end

        // Clean press (1,2) for 200 clocks
        base  = pulse_cnt;
        moved = 1'b0;
        pressed[1*4+2] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (pulse_cnt != base && col !== 4'b1011) moved = 1'b1;
        end
        check("clean_pulses", 32'(pulse_cnt - base), 32'd1);
        check("clean_code", 32'(last_code), 32'h6);
        check("clean_held", 32'(key_held), 32'd1);
        check("clean_col_frozen", 32'(col), 32'hb);
        check("clean_col_moved", 32'(moved), 32'd0);
        pressed = '0;
        wait_held_low(40, "clean");
        check("clean_col_after", 32'(col), 32'h7);

        // Bounce on (3,0): 3 clocks on, 3 off
        base = pulse_cnt;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[3*4+0] = ~pressed[3*4+0];
            step(1);
        end
        check("bounce_no_pulse", 32'(pulse_cnt - base), 32'd0);
        pressed[3*4+0] = 1'b1;
        wait_pulse(base, 120, "bounce");
        step(20);
        check("bounce_pulses", 32'(pulse_cnt - base), 32'd1);
        check("bounce_code", 32'(key_code), 32'h0);
        check("bounce_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_held_low(60, "bounce");

        // Glitch on (0,3) lasting one tick sample
        base = pulse_cnt;
        wait_col(4'b0111, 1'b0, 40);
        wait_col(4'b0111, 1'b1, 40);
        pressed[0*4+3] = 1'b1;
        step(4);
        check("glitch_debounce_hold", 32'(col), 32'h7);
        pressed = '0;
        step(4);
        check("glitch_abort_advance", 32'(col), 32'he);
        step(40);
        check("glitch_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("glitch_code_kept", 32'(key_code), 32'h0);
        check("glitch_held", 32'(key_held), 32'd0);

        // Two keys in column 1 are never accepted; scanning keeps going
        base    = pulse_cnt;
        changes = 0;
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        prev = col;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (col !== prev) changes++;
            prev = col;
        end
        check("multi_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("multi_scanning", 32'(changes >= 20), 32'd1);
        check("multi_held", 32'(key_held), 32'd0);
        pressed = '0;

        // Held (2,3); a second key in the same column is ignored
        step(8);
        base = pulse_cnt;
        pressed[2*4+3] = 1'b1;
        wait_pulse(base, 120, "held");
        step(2);
        check("held_code", 32'(key_code), 32'hc);
        check("held_flag", 32'(key_held), 32'd1);
        check("held_col", 32'(col), 32'h7);
        pressed[0*4+3] = 1'b1;
        step(60);
        check("second_pulses", 32'(pulse_cnt - base), 32'd1);
        check("second_code", 32'(key_code), 32'hc);
        pressed[2*4+3] = 1'b0;
        step(60);
        check("second_still_held", 32'(key_held), 32'd1);
        check("second_no_pulse", 32'(pulse_cnt - base), 32'd1);
        pressed = '0;
        wait_held_low(60, "second");

        // Reset while (1,1) is held, key stays pressed through reset
        base = pulse_cnt;
        pressed[1*4+1] = 1'b1;
        wait_pulse(base, 120, "prereset");
        step(2);
        check("prereset_code", 32'(key_code), 32'h5);
        check("prereset_held", 32'(key_held), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("hrst_held", 32'(key_held), 32'd0);
        check("hrst_valid", 32'(key_valid), 32'd0);
        check("hrst_code", 32'(key_code), 32'd0);
        check("hrst_col", 32'(col), 32'he);
        step(2);
        base = pulse_cnt;
        rst = 1'b0;
        wait_pulse(base, 120, "after_rst");
        step(20);
        check("after_rst_pulses", 32'(pulse_cnt - base), 32'd1);
        check("after_rst_code", 32'(key_code), 32'h5);
        check("after_rst_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_held_low(60, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
